// File: rtl/spike_event_encoder_if.sv
// Event output bus of the spike encoder.
//   evt_data  : head event word {id[1:0], ts[5:0]}
//   evt_valid : a head event is present
//   evt_ready : consumer takes the head event when high together with evt_valid
// master = encoder side, slave = consumer side.
interface spike_event_encoder_if;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;

  modport master (output evt_data, output evt_valid, input evt_ready);
  modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/spike_event_encoder.sv
// Spike event encoder: turns rising edges on four neuron spike lines into
// timestamped events and queues them in a 4-deep in-order FIFO.
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   spike_in   : level spike lines, bit i = neuron i
//   ovf_clr    : synchronous clear of the sticky overflow flag
//   overflow   : set when a spike edge had to be dropped
//   fifo_count : events held in the FIFO, 0..4
//   evt        : event bus (data / valid / ready)
module spike_event_encoder #(
  parameter int unsigned TS_PRESCALE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    spike_in,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic [2:0]                    fifo_count,
  spike_event_encoder_if.master         evt
);

  logic [3:0] spike_q;
  logic [3:0] pending_q, pending_d;
  logic [5:0] ts_q;
  logic [7:0] presc_q;
  logic [7:0] mem_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;
  logic       ovf_q;

  logic [3:0] rise;
  logic [3:0] clr_mask;
  logic [1:0] win_id;
  logic       win_vld;
  logic       push, pop, drop, presc_wrap;

  assign rise = spike_in & ~spike_q;

  // Lowest-index pending neuron wins the single push slot of the cycle.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_vld = 1'b1;
        win_id  = 2'(i);
      end
    end
  end

  // Push eligibility looks only at the current fill level; a same-cycle pop
  // does not open a slot for a push into a full FIFO.
  assign push       = win_vld && (count_q != 3'd4);
  assign pop        = (count_q != 3'd0) && evt.evt_ready;
  assign clr_mask   = push ? (4'b0001 << win_id) : 4'b0000;
  // A new edge on the neuron being pushed this cycle re-arms pending and is kept.
  assign pending_d  = (pending_q & ~clr_mask) | rise;
  assign drop       = |(rise & pending_q & ~clr_mask);
  assign presc_wrap = (presc_q == 8'(TS_PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q   <= 4'd0;
      pending_q <= 4'd0;
      ts_q      <= 6'd0;
      presc_q   <= 8'd0;
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'd0;
    end else begin
      spike_q   <= spike_in;
      pending_q <= pending_d;

      if (presc_wrap) begin
        presc_q <= 8'd0;
        ts_q    <= ts_q + 6'd1;
      end else begin
        presc_q <= presc_q + 8'd1;
      end

      if (push) begin
        mem_q[wr_ptr_q] <= {win_id, ts_q};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase

      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign evt.evt_valid = (count_q != 3'd0);
  assign evt.evt_data  = mem_q[rd_ptr_q];
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter: TS_PRESCALE, default 1, clock cycles per timestamp increment (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 spike_in  input  4  spike lines from four LIF neurons, bit i = neuron i, level signal, may stay high several cycles.
REQ-005 evt_data  output  8  head event {id[1:0], ts[5:0]}.
REQ-006 evt_valid  output  1  FIFO non-empty; evt_data valid.
REQ-007 evt_ready  input  1  consumer accepts head event when high with evt_valid.
REQ-008 ovf_clr  input  1  synchronous clear of overflow flag.
REQ-009 overflow  output  1  sticky flag; at least one spike event dropped.
REQ-010 fifo_count  output  3  events currently stored, 0..4.

Function
REQ-011 Edge detect: spike_q[3:0] SHALL register spike_in each cycle; event for neuron i SHALL be spike_in[i] & ~spike_q[i] at a clock edge; a held-high line yields exactly one event.
REQ-012 Pending: detected event SHALL set pending[i] at that edge; pending[i] SHALL clear only on the edge its event is pushed.
REQ-013 Arbitration: each cycle at most one push; lowest-index pending bit wins; push occurs only when fifo_count < 4, regardless of a same-cycle pop.
REQ-014 Timestamp: 6-bit ts counter SHALL increment by 1 every TS_PRESCALE cycles, wrap 63 -> 0; prescaler counter resets to 0 and increments ts when reaching TS_PRESCALE-1.
REQ-015 Pushed word SHALL be {id, ts} where ts is the counter value before the push edge updates it.
REQ-016 FIFO: 4 entries, in-order; pop when evt_valid & evt_ready; simultaneous push and pop SHALL keep fifo_count unchanged and preserve order.
REQ-017 Latency: spike_in[i] rising before edge k (with spike_q[i]=0) -> pending at k -> pushed at k+1 (if winner and not full) -> evt_valid high after k+1.
REQ-018 evt_data SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-019 Overflow: if a new edge occurs on neuron i while pending[i]=1 and pending[i] is not cleared at that edge, the event SHALL be dropped and overflow set.
REQ-020 If the new edge coincides with the push of pending[i], pending[i] SHALL remain set (new event kept, no overflow).
REQ-021 ovf_clr=1 SHALL clear overflow at the edge, except that a drop in the same cycle SHALL win (overflow stays 1).
REQ-022 evt_ready with FIFO empty SHALL have no effect; fifo_count never underflows or exceeds 4.

Reset
REQ-023 rst_n=0 SHALL immediately force: spike_q=0, pending=0, ts=0, prescaler=0, FIFO empty, fifo_count=0, evt_valid=0, evt_data=0, overflow=0.
REQ-024 Reset mid-operation SHALL discard all stored and pending events; after release, a line already high SHALL produce one event (spike_q was 0).
REQ-025 First edge after rst_n rises SHALL be treated as normal operation; no event produced without a rising spike_in.

Verification
REQ-026 Single spike: TS_PRESCALE=1, evt_ready=0, spike_in=4'b0100 at ts=5 -> evt_valid after 2 edges, evt_data={2'd2, 6'd6}, fifo_count=1; held line gives no second event.
REQ-027 Simultaneous: spike_in 0000 -> 1111 in one cycle -> four events in ids 0,1,2,3, consecutive ts values, fifo_count=4, overflow=0.
REQ-028 Full/overflow: FIFO full, evt_ready=0, neuron 0 pulses twice (pending already set) -> overflow=1, fifo_count=4; ovf_clr pulse -> overflow=0.
REQ-029 Streaming: evt_ready=1 constant, neuron 1 pulses every 3 cycles for 20 pulses -> 20 events in order, fifo_count never exceeds 1, ts wraps 63 -> 0 correctly.
REQ-030 Prescale: TS_PRESCALE=4 -> ts increments every 4 cycles; event pushed on cycle 9 after reset carries ts=2.
REQ-031 Reset: assert rst_n mid-stream with 3 events stored -> evt_valid=0, fifo_count=0, overflow=0 immediately; spike_in[3] held high through release -> exactly one id-3 event.
